// File: rtl/audipus_audio_pkg.sv
// Shared parameters and FSM encoding for the I2S DAC output path.
// Frame geometry is derived here so every stage agrees on it.
package audipus_audio_pkg;

    localparam int DIN_W         = 34;
    localparam int DOUT_W        = 24;
    localparam int DROP_BITS     = 10;
    localparam int MCLK_PER_BCLK = 8;
    localparam int SLOT_BITS     = 32;

    localparam int DIV_W  = $clog2(MCLK_PER_BCLK);
    localparam int SLOT_W = $clog2(SLOT_BITS);
    localparam int CNT_W  = SLOT_W + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

endpackage

// File: rtl/i2s_round_sat.sv
// Round-half-up and saturate a DIN_W sample down to DOUT_W.
// The sum is one bit wider so the rounding carry cannot wrap.
module i2s_round_sat
    import audipus_audio_pkg::*;
(
    input  logic [DIN_W-1:0]  x,
    output logic [DOUT_W-1:0] y
);

    localparam int SUM_W = DIN_W + 1;
    localparam int Q_W   = SUM_W - DROP_BITS;
    localparam logic [SUM_W-1:0] HALF =
        SUM_W'(1) << (DROP_BITS - 1);

    logic [SUM_W-1:0] sum;
    logic [Q_W-1:0]   q;
    logic             ovf;
    logic             unused_lsbs;

    assign sum = {x[DIN_W-1], x} + HALF;
    assign q   = sum[SUM_W-1:DROP_BITS];
    assign unused_lsbs = ^sum[DROP_BITS-1:0];

    // Fits only if every bit above the output sign matches the sign.
    assign ovf = q[Q_W-1:DOUT_W-1] !=
                 {(Q_W-DOUT_W+1){q[Q_W-1]}};

    always_comb begin
        y = q[DOUT_W-1:0];
        if (ovf) begin
            y = q[Q_W-1] ? {1'b1, {(DOUT_W-1){1'b0}}}
                         : {1'b0, {(DOUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/i2s_dac_transmitter.sv
// Double-buffered I2S transmitter: 24-bit left-justified-after-one
// slots, 64 bclk per frame, frames generated from mclk.
module i2s_dac_transmitter
    import audipus_audio_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             mute,
    input  logic             din_valid,
    input  logic [DIN_W-1:0] l_data_in,
    input  logic [DIN_W-1:0] r_data_in,
    input  logic             clear_status,
    output logic             bclk,
    output logic             lrclk,
    output logic             sdata,
    output logic             frame_start,
    output logic             underrun,
    output logic             overrun
);

    logic [1:0]        state;
    logic [DIV_W-1:0]  clk_div;
    logic [CNT_W-1:0]  bit_cnt;
    logic [SLOT_W-1:0] slot_bit;
    logic [DOUT_W-1:0] l_conv, r_conv;
    logic [DOUT_W-1:0] l_buf, r_buf;
    logic [DOUT_W-1:0] l_sh, r_sh;
    logic              fresh;
    logic              run, load, div_wrap;
    logic              accept, data_bit;

    i2s_round_sat u_rs_l (.x(l_data_in), .y(l_conv));
    i2s_round_sat u_rs_r (.x(r_data_in), .y(r_conv));

    assign run      = (state == ST_RUN) && enable;
    assign load     = run && clk_div == '0 && bit_cnt == '0;
    assign div_wrap = run && (&clk_div);
    assign accept   = enable && din_valid;
    assign slot_bit = bit_cnt[SLOT_W-1:0];
    assign data_bit = slot_bit != '0 &&
                      slot_bit <= SLOT_W'(DOUT_W);

    assign bclk        = run && clk_div[DIV_W-1];
    assign lrclk       = run && bit_cnt[CNT_W-1];
    assign frame_start = load;
    assign sdata = run && data_bit &&
                   (bit_cnt[CNT_W-1] ? r_sh[DOUT_W-1]
                                     : l_sh[DOUT_W-1]);

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: state <= ST_WAIT;
                ST_WAIT: if (din_valid) state <= ST_RUN;
                ST_RUN:  state <= ST_RUN;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !run) begin
            clk_div <= '0;
            bit_cnt <= '0;
        end else begin
            clk_div <= clk_div + 1'b1;
            if (div_wrap) bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // A sample arriving on the load clock is not an overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            l_buf    <= '0;
            r_buf    <= '0;
            fresh    <= 1'b0;
            underrun <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (clear_status) begin
                underrun <= 1'b0;
                overrun  <= 1'b0;
            end
            if (accept) begin
                l_buf <= l_conv;
                r_buf <= r_conv;
            end
            if (load) begin
                fresh <= accept;
                if (!fresh) underrun <= 1'b1;
            end else if (accept) begin
                fresh <= 1'b1;
                if (fresh) overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            l_sh <= '0;
            r_sh <= '0;
        end else if (load) begin
            l_sh <= mute ? '0 : l_buf;
            r_sh <= mute ? '0 : r_buf;
        end else if (div_wrap && data_bit) begin
            if (bit_cnt[CNT_W-1])
                r_sh <= {r_sh[DOUT_W-2:0], 1'b0};
            else
                l_sh <= {l_sh[DOUT_W-2:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_i2s_dac_transmitter.sv
// Bench for i2s_dac_transmitter: vector table plus frame scoreboard.
// A monitor decodes every full I2S frame into a receive queue.
module tb_i2s_dac_transmitter;

    typedef struct {
        logic [33:0] l_in;
        logic [33:0] r_in;
        logic [23:0] l_exp;
        logic [23:0] r_exp;
    } vec_t;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
    } pair_t;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        bit          pad_ok;
        bit          tim_ok;
    } frame_t;

    logic        clk = 1'b0;
    logic        reset, enable, mute, din_valid, clear_status;
    logic [33:0] l_data_in, r_data_in;
    logic        bclk, lrclk, sdata, frame_start;
    logic        underrun, overrun;

    int     n_tests = 0;
    int     n_fail  = 0;
    vec_t   vecs[6];
    pair_t  sb[$];
    frame_t rxq[$];

    int          cyc = 0;
    bit          mon_active = 1'b0;
    logic [63:0] bits;
    bit          tim_err;
    logic        s1;

    always #5 clk = ~clk;

    i2s_dac_transmitter dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .mute         (mute),
        .din_valid    (din_valid),
        .l_data_in    (l_data_in),
        .r_data_in    (r_data_in),
        .clear_status (clear_status),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .frame_start  (frame_start),
        .underrun     (underrun),
        .overrun      (overrun)
    );

    task automatic check(input string name,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h",
                     name, got, exp);
        end
    endtask

    // Frame decoder; cyc 0 is the load clock.
    always @(negedge clk) begin
        if (reset || !enable) begin
            mon_active = 1'b0;
            cyc = 0;
        end else begin
            if (frame_start) begin
                if (mon_active)
                    check("frame_period", cyc + 1, 512);
                mon_active = 1'b1;
                cyc = 0;
                tim_err = 1'b0;
                bits = '0;
            end else if (mon_active) begin
                cyc++;
            end
            if (mon_active && cyc < 512) begin
                automatic int b  = cyc / 8;
                automatic int ph = cyc % 8;
                if (bclk !== (ph >= 4)) tim_err = 1'b1;
                if (lrclk !== (b >= 32)) tim_err = 1'b1;
                if (ph == 1) s1 = sdata;
                if (ph == 4) begin
                    bits[b] = sdata;
                    if (sdata !== s1) tim_err = 1'b1;
                end
                if (ph == 7 && sdata !== bits[b])
                    tim_err = 1'b1;
                if (cyc == 511) begin
                    automatic frame_t f;
                    for (int i = 0; i < 24; i++) begin
                        f.l[23-i] = bits[1+i];
                        f.r[23-i] = bits[33+i];
                    end
                    f.pad_ok = bits[0] == 1'b0 &&
                               bits[31:25] == '0 &&
                               bits[32] == 1'b0 &&
                               bits[63:57] == '0;
                    f.tim_ok = !tim_err;
                    rxq.push_back(f);
                end
            end
        end
    end

    task automatic push_exp(input logic [23:0] el,
                            input logic [23:0] er);
        pair_t p;
        p.l = el;
        p.r = er;
        sb.push_back(p);
    endtask

    task automatic send(input logic [33:0] l,
                        input logic [33:0] r,
                        input logic [23:0] el,
                        input logic [23:0] er,
                        input bit push);
        l_data_in = l;
        r_data_in = r;
        din_valid = 1'b1;
        if (push) push_exp(el, er);
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic send_w(input logic [23:0] wl,
                          input logic [23:0] wr,
                          input bit push);
        send({wl, 10'd0}, {wr, 10'd0}, wl, wr, push);
    endtask

    task automatic wait_cyc(input int n);
        int k = 0;
        while (cyc != n && k < 1100) begin
            @(negedge clk);
            k++;
        end
        if (cyc != n) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_cyc: got %0d, expected %0d",
                     cyc, n);
        end
    endtask

    task automatic wait_fs();
        int k = 0;
        while (frame_start !== 1'b1 && k < 1100) begin
            @(negedge clk);
            k++;
        end
        if (frame_start !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_fs: got 0, expected 1");
        end
    endtask

    task automatic expect_frame(input string tag);
        int k = 0;
        frame_t f;
        pair_t  p;
        while (rxq.size() == 0 && k < 1200) begin
            @(negedge clk);
            k++;
        end
        if (rxq.size() == 0 || sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got rx=%0d sb=%0d, expected both",
                     tag, rxq.size(), sb.size());
        end else begin
            f = rxq.pop_front();
            p = sb.pop_front();
            check({tag, "_left"}, f.l, p.l);
            check({tag, "_right"}, f.r, p.r);
            check({tag, "_pad"}, f.pad_ok, 1);
            check({tag, "_timing"}, f.tim_ok, 1);
        end
    endtask

    task automatic pulse_clear();
        clear_status = 1'b1;
        @(negedge clk);
        clear_status = 1'b0;
    endtask

    initial begin
        vecs[0] = '{{24'h123456, 10'd0}, {24'hABCDEF, 10'd0},
                    24'h123456, 24'hABCDEF};
        vecs[1] = '{34'h0_0000_0200, 34'h0_0000_01FF,
                    24'h000001, 24'h000000};
        vecs[2] = '{34'h1_FFFF_FE00, 34'h2_0000_0000,
                    24'h7FFFFF, 24'h800000};
        vecs[3] = '{34'h3_FFFF_FE00, 34'h3_FFFF_FDFF,
                    24'h000000, 24'hFFFFFF};
        vecs[4] = '{34'h1_FFFF_FDFF, 34'h0_0000_0600,
                    24'h7FFFFF, 24'h000002};
        vecs[5] = '{34'h1_FFFF_FFFF, 34'h3_FFFF_FE01,
                    24'h7FFFFF, 24'h000000};

        reset = 1'b1;
        enable = 1'b0;
        mute = 1'b0;
        din_valid = 1'b0;
        clear_status = 1'b0;
        l_data_in = '0;
        r_data_in = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {bclk, lrclk, sdata, frame_start}, 0);
        check("reset_flags", {underrun, overrun}, 0);

        reset = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        repeat (4) @(negedge clk);
        check("wait_outputs",
              {bclk, lrclk, sdata, frame_start}, 0);

        send(vecs[0].l_in, vecs[0].r_in,
             vecs[0].l_exp, vecs[0].r_exp, 1);
        check("first_load_latency", frame_start, 1);

        for (int i = 1; i < 6; i++) begin
            wait_cyc(200);
            check("no_underrun", underrun, 0);
            send(vecs[i].l_in, vecs[i].r_in,
                 vecs[i].l_exp, vecs[i].r_exp, 1);
            expect_frame("round");
        end

        wait_cyc(200);
        push_exp(vecs[5].l_exp, vecs[5].r_exp);
        expect_frame("last_vec");

        wait_cyc(200);
        check("underrun_set", underrun, 1);
        send_w(24'h13579B, 24'h2468AC, 1);
        wait_cyc(210);
        pulse_clear();
        check("underrun_clear", underrun, 0);
        expect_frame("repeat");

        wait_cyc(100);
        send_w(24'hAAAAAA, 24'h555555, 0);
        wait_cyc(200);
        send_w(24'hB0B0B0, 24'h0B0B0B, 1);
        check("overrun_set", overrun, 1);
        wait_cyc(300);
        pulse_clear();
        check("overrun_clear", overrun, 0);
        expect_frame("pre_overrun");

        wait_cyc(100);
        send_w(24'hC0FFEE, 24'h00C0DE, 0);
        wait_cyc(200);
        clear_status = 1'b1;
        send_w(24'hD00D00, 24'h0DD0DD, 1);
        clear_status = 1'b0;
        check("clear_vs_set", overrun, 1);
        wait_cyc(300);
        pulse_clear();
        expect_frame("overrun_newest");

        wait_cyc(200);
        mute = 1'b1;
        send_w(24'hEEEEEE, 24'h111111, 0);
        push_exp(24'h000000, 24'h000000);
        expect_frame("pre_mute");

        wait_cyc(200);
        mute = 1'b0;
        send_w(24'hF00F00, 24'h0FF0FF, 1);
        expect_frame("mute");

        wait_cyc(200);
        send_w(24'h654321, 24'h876543, 1);
        expect_frame("pre_coincide");
        wait_fs();
        send_w(24'h9ABCDE, 24'h7E7E7E, 1);
        expect_frame("coincide_old");
        expect_frame("coincide_new");
        check("coincide_underrun", underrun, 0);
        check("coincide_overrun", overrun, 0);

        wait_cyc(100);
        enable = 1'b0;
        @(negedge clk);
        check("disable_outputs",
              {bclk, lrclk, sdata, frame_start}, 0);
        repeat (20) @(negedge clk);
        check("disable_hold",
              {bclk, lrclk, sdata, frame_start}, 0);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check("reenable_wait",
              {bclk, lrclk, sdata, frame_start}, 0);
        send_w(24'h5A5A5A, 24'hA5A5A5, 1);
        check("reenable_load", frame_start, 1);
        expect_frame("reenable");
        check("underrun_sticky", underrun, 1);

        wait_cyc(250);
        reset = 1'b1;
        @(negedge clk);
        check("reset_mid_outputs",
              {bclk, lrclk, sdata, frame_start}, 0);
        check("reset_mid_flags", {underrun, overrun}, 0);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("post_reset_idle",
              {bclk, lrclk, sdata, frame_start}, 0);
        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed",
                 n_tests, n_fail);
        $finish;
    end

endmodule
